// File: rtl/tdp18k_port_arbiter.sv
// Round-robin arbiter sharing port A of a TDP18K (RAM mode, 18-bit) among
// NUM_REQ requesters. One command is registered per cycle. Read data comes
// back two cycles after the grant, tagged with the one-hot requester ID.
// An optional clear sequencer zero-fills all 1024 words after reset.
module tdp18k_port_arbiter #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                   CLK_i,
  input  logic                   RST_ni,
  input  logic [NUM_REQ-1:0]     REQ_i,
  input  logic [NUM_REQ-1:0]     WE_i,
  input  logic [NUM_REQ*10-1:0]  ADDR_i,
  input  logic [NUM_REQ*18-1:0]  WDATA_i,
  input  logic [NUM_REQ*2-1:0]   BE_i,
  output logic [NUM_REQ-1:0]     GNT_o,
  output logic [NUM_REQ-1:0]     RVALID_o,
  output logic [17:0]            RDATA_o,
  output logic                   BUSY_o,
  output logic                   WEN_A_o,
  output logic                   REN_A_o,
  output logic [13:0]            ADDR_A_o,
  output logic [17:0]            WDATA_A_o,
  output logic [1:0]             BE_A_o,
  output logic [2:0]             WMODE_A_o,
  output logic [2:0]             RMODE_A_o,
  input  logic [17:0]            RDATA_A_i
);

  localparam int unsigned PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic {
    ST_CLEAR,
    ST_ARB
  } state_t;

  state_t              state, state_next;
  logic [PW-1:0]       ptr;
  logic [PW-1:0]       win;
  logic [PW-1:0]       idx;
  logic                any_req;
  logic [9:0]          cnt;
  logic [NUM_REQ-1:0]  gnt;
  logic [NUM_REQ-1:0]  rd_tag;
  logic [NUM_REQ-1:0]  rvalid;

  logic [9:0]          addr_arr  [NUM_REQ];
  logic [17:0]         wdata_arr [NUM_REQ];
  logic [1:0]          be_arr    [NUM_REQ];

  // Unpack the flat per-requester buses into arrays indexed by requester.
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = ADDR_i[g*10 +: 10];
    assign wdata_arr[g] = WDATA_i[g*18 +: 18];
    assign be_arr[g]    = BE_i[g*2 +: 2];
  end

  // Round-robin search: first requester after the last winner.
  always_comb begin
    any_req = 1'b0;
    win     = '0;
    idx     = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      idx = PW'((32'(ptr) + i) % NUM_REQ);
      if (!any_req && REQ_i[idx]) begin
        any_req = 1'b1;
        win     = idx;
      end
    end
  end

  // Next state and combinational grant.
  always_comb begin
    state_next = state;
    gnt        = '0;
    case (state)
      ST_CLEAR: begin
        if (cnt == 10'h3FF) state_next = ST_ARB;
      end
      ST_ARB: begin
        if (RST_ni && any_req) gnt[win] = 1'b1;
      end
      default: state_next = ST_ARB;
    endcase
  end

  // State register.
  always_ff @(posedge CLK_i) begin
    if (!RST_ni) state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_ARB;
    else         state <= state_next;
  end

  // Command stage, round-robin pointer, clear counter and read tag pipeline.
  always_ff @(posedge CLK_i) begin
    if (!RST_ni) begin
      ptr       <= PW'(NUM_REQ - 1);
      cnt       <= '0;
      WEN_A_o   <= 1'b0;
      REN_A_o   <= 1'b0;
      BE_A_o    <= '0;
      ADDR_A_o  <= '0;
      WDATA_A_o <= '0;
      rd_tag    <= '0;
      rvalid    <= '0;
    end else begin
      // A read tag rides alongside REN_A_o, then marks the cycle RAM data is out.
      rvalid  <= rd_tag;
      rd_tag  <= '0;
      WEN_A_o <= 1'b0;
      REN_A_o <= 1'b0;
      case (state)
        ST_CLEAR: begin
          WEN_A_o   <= 1'b1;
          BE_A_o    <= 2'b11;
          WDATA_A_o <= '0;
          ADDR_A_o  <= {cnt, 4'b0000};
          cnt       <= cnt + 10'd1;
        end
        ST_ARB: begin
          if (any_req) begin
            ptr       <= win;
            WEN_A_o   <= WE_i[win];
            REN_A_o   <= ~WE_i[win];
            ADDR_A_o  <= {addr_arr[win], 4'b0000};
            WDATA_A_o <= wdata_arr[win];
            BE_A_o    <= WE_i[win] ? be_arr[win] : 2'b00;
            if (!WE_i[win]) rd_tag <= gnt;
          end else begin
            BE_A_o <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign GNT_o     = gnt;
  assign RVALID_o  = rvalid;
  assign RDATA_o   = RDATA_A_i;
  assign BUSY_o    = (state == ST_CLEAR);
  assign WMODE_A_o = 3'b010;
  assign RMODE_A_o = 3'b010;

endmodule

// File: tb/tb_tdp18k_port_arbiter.sv
// Directed bench for tdp18k_port_arbiter with a behavioural port-A RAM model.
module tb_tdp18k_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req, we;
  logic [9:0]  a [4];
  logic [17:0] d [4];
  logic [1:0]  b [4];

  logic [3:0]  gnt, rvalid;
  logic [17:0] rdata, wdata_a, ram_q;
  logic        busy, wen_a, ren_a;
  logic [13:0] addr_a;
  logic [1:0]  be_a;
  logic [2:0]  wmode, rmode;

  logic [17:0] mem [1024];

  int nchk  = 0;
  int npass = 0;
  int nfail = 0;

  always #5 clk = ~clk;

  tdp18k_port_arbiter #(.NUM_REQ(4), .CLEAR_ON_RESET(1)) dut (
    .CLK_i     (clk),
    .RST_ni    (rst_n),
    .REQ_i     (req),
    .WE_i      (we),
    .ADDR_i    ({a[3], a[2], a[1], a[0]}),
    .WDATA_i   ({d[3], d[2], d[1], d[0]}),
    .BE_i      ({b[3], b[2], b[1], b[0]}),
    .GNT_o     (gnt),
    .RVALID_o  (rvalid),
    .RDATA_o   (rdata),
    .BUSY_o    (busy),
    .WEN_A_o   (wen_a),
    .REN_A_o   (ren_a),
    .ADDR_A_o  (addr_a),
    .WDATA_A_o (wdata_a),
    .BE_A_o    (be_a),
    .WMODE_A_o (wmode),
    .RMODE_A_o (rmode),
    .RDATA_A_i (ram_q)
  );

  // Port-A RAM: byte 0 = {bit16, bits 7:0}, byte 1 = {bit17, bits 15:8}.
  // Seeded with a non-zero pattern while reset is low so the clear is visible.
  always @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 18'h2AAAA;
    end else if (wen_a) begin
      if (be_a[0]) begin
        mem[addr_a[13:4]][7:0] <= wdata_a[7:0];
        mem[addr_a[13:4]][16]  <= wdata_a[16];
      end
      if (be_a[1]) begin
        mem[addr_a[13:4]][15:8] <= wdata_a[15:8];
        mem[addr_a[13:4]][17]   <= wdata_a[17];
      end
    end
    if (ren_a) ram_q <= mem[addr_a[13:4]];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, nchk=%0d", nchk);
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] bus(input logic w, input logic r, input logic [1:0] be,
                                      input logic [17:0] wd, input logic [13:0] ad);
    return {28'd0, w, r, be, wd, ad};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) npass++;
    else begin
      nfail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Entered in the first cycle after reset release; leaves in the first ARB cycle.
  task automatic run_clear();
    for (int i = 0; i < 1024; i++) begin
      #1;
      chk("clear_busy_gnt_rvalid", 64'({busy, gnt, rvalid}), 64'({1'b1, 4'b0000, 4'b0000}));
      if (i == 0)
        chk("clear_bus_after_reset", bus(wen_a, ren_a, be_a, wdata_a, addr_a),
            bus(1'b0, 1'b0, 2'b00, 18'h0, 14'h0));
      else
        chk("clear_write", bus(wen_a, ren_a, be_a, wdata_a, addr_a),
            bus(1'b1, 1'b0, 2'b11, 18'h0, {10'(i - 1), 4'h0}));
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 4'b1111;
    we    = 4'b0000;
    for (int k = 0; k < 4; k++) begin
      a[k] = 10'h010 + 10'(k);
      d[k] = 18'h0;
      b[k] = 2'b11;
    end

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus", bus(wen_a, ren_a, be_a, wdata_a, addr_a), bus(1'b0, 1'b0, 2'b00, 18'h0, 14'h0));
    chk("rst_busy_gnt_rvalid", 64'({busy, gnt, rvalid}), 64'({1'b1, 4'b0000, 4'b0000}));
    chk("modes", 64'({wmode, rmode}), 64'(6'b010010));

    // Clear sequence with all four requesting.
    rst_n = 1'b1;
    run_clear();

    // Round-robin reads, RVALID two cycles behind the grant.
    for (int j = 0; j < 10; j++) begin
      if (j == 8) req = 4'b0000;
      #1;
      if (j == 0) begin
        chk("clear_last_write", bus(wen_a, ren_a, be_a, wdata_a, addr_a),
            bus(1'b1, 1'b0, 2'b11, 18'h0, 14'h3FF0));
        chk("busy_dropped", 64'(busy), 64'(1'b0));
      end
      chk("rr_gnt", 64'(gnt), (j < 8) ? 64'(4'b0001 << (j % 4)) : 64'(0));
      if (j >= 1 && j <= 8)
        chk("rr_read_cmd", bus(wen_a, ren_a, be_a, wdata_a, addr_a),
            bus(1'b0, 1'b1, 2'b00, 18'h0, {10'h010 + 10'((j - 1) % 4), 4'h0}));
      if (j >= 2) begin
        chk("rr_rvalid", 64'(rvalid), 64'(4'b0001 << ((j - 2) % 4)));
        chk("rr_rdata_cleared", 64'(rdata), 64'(0));
      end
      tick();
    end

    // Write by requester 2 then read-after-write by requester 1.
    req = 4'b0100; we[2] = 1'b1; a[2] = 10'h155; d[2] = 18'h2ABCD; b[2] = 2'b11;
    #1;
    chk("raw_wr_gnt", 64'(gnt), 64'(4'b0100));
    tick();
    req = 4'b0010; we[1] = 1'b0; a[1] = 10'h155;
    #1;
    chk("raw_rd_gnt", 64'(gnt), 64'(4'b0010));
    chk("raw_wr_cmd", bus(wen_a, ren_a, be_a, wdata_a, addr_a),
        bus(1'b1, 1'b0, 2'b11, 18'h2ABCD, 14'h1550));
    tick();
    req = 4'b0000;
    #1;
    chk("raw_rd_cmd", bus(wen_a, ren_a, be_a, wdata_a, addr_a),
        bus(1'b0, 1'b1, 2'b00, 18'h0, 14'h1550));
    chk("raw_rvalid_early", 64'(rvalid), 64'(0));
    tick();
    #1;
    chk("raw_rvalid", 64'(rvalid), 64'(4'b0010));
    chk("raw_rdata", 64'(rdata), 64'(18'h2ABCD));
    tick();

    // Partial byte-enable write over cleared RAM.
    req = 4'b0001; we[0] = 1'b1; a[0] = 10'h007; d[0] = 18'h3FFFF; b[0] = 2'b01;
    #1;
    chk("be_wr_gnt", 64'(gnt), 64'(4'b0001));
    tick();
    req = 4'b1000; we[3] = 1'b0; a[3] = 10'h007;
    #1;
    chk("be_rd_gnt", 64'(gnt), 64'(4'b1000));
    chk("be_wr_cmd", bus(wen_a, ren_a, be_a, wdata_a, addr_a),
        bus(1'b1, 1'b0, 2'b01, 18'h3FFFF, 14'h0070));
    tick();
    req = 4'b0000;
    tick();
    #1;
    chk("be_rvalid", 64'(rvalid), 64'(4'b1000));
    chk("be_rdata", 64'(rdata), 64'(18'h100FF));
    tick();

    // Reset pulse while a read is in flight.
    req = 4'b0010; we[1] = 1'b0; a[1] = 10'h155;
    #1;
    chk("rst_rd_gnt", 64'(gnt), 64'(4'b0010));
    tick();
    rst_n = 1'b0; req = 4'b1111; we = 4'b0000;
    #1;
    chk("rst_gnt_gated", 64'(gnt), 64'(0));
    chk("rst_inflight_cmd", bus(wen_a, ren_a, be_a, wdata_a, addr_a),
        bus(1'b0, 1'b1, 2'b00, 18'h0, 14'h1550));
    tick();
    rst_n = 1'b1;
    run_clear();
    #1;
    chk("rst_ptr_gnt", 64'(gnt), 64'(4'b0001));
    tick();

    // Lone requester 3, then requester 0 joins.
    req = 4'b1000;
    for (int j = 0; j < 5; j++) begin
      #1;
      chk("solo_gnt", 64'(gnt), 64'(4'b1000));
      tick();
    end
    req = 4'b1001;
    #1;
    chk("join_gnt0", 64'(gnt), 64'(4'b0001));
    tick();
    #1;
    chk("join_gnt3", 64'(gnt), 64'(4'b1000));
    tick();
    req = 4'b0000;
    tick();

    $display("%0d/%0d checks passed", npass, nchk);
    $finish;
  end

endmodule
